// File: rtl/fifo_burst_reader_if.sv
// Bundle of the burst reader's request, fifo-side and downstream signals.
// master is the reader's view; slave is the view of whatever drives and consumes it.
interface fifo_burst_reader_if #(
   parameter int WIDTH    = 16,
   parameter int LEN_BITS = 8
);
   logic                start;
   logic [LEN_BITS-1:0] length;
   logic                abort;
   logic                fifo_pop;
   logic [WIDTH-1:0]    fifo_data;
   logic                fifo_nempty;
   logic                m_valid;
   logic                m_ready;
   logic [WIDTH-1:0]    m_data;
   logic                m_last;
   logic                busy;
   logic                done;
   logic [LEN_BITS-1:0] words_left;

   modport master (
      input  start,
      input  length,
      input  abort,
      output fifo_pop,
      input  fifo_data,
      input  fifo_nempty,
      output m_valid,
      input  m_ready,
      output m_data,
      output m_last,
      output busy,
      output done,
      output words_left
   );

   modport slave (
      output start,
      output length,
      output abort,
      input  fifo_pop,
      output fifo_data,
      output fifo_nempty,
      input  m_valid,
      output m_ready,
      input  m_data,
      input  m_last,
      input  busy,
      input  done,
      input  words_left
   );
endinterface

// File: rtl/fifo_burst_reader.sv
// Reads a fixed-length burst from a fifo with one cycle of read latency and
// presents it on a valid/ready stream through a 2-entry skid buffer.
module fifo_burst_reader #(
   parameter int WIDTH    = 16,
   parameter int LEN_BITS = 8
) (
   input logic                  clock,
   input logic                  reset_n,
   fifo_burst_reader_if.master  bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [LEN_BITS-1:0] LEN_ZERO = '0;
   localparam logic [LEN_BITS-1:0] LEN_ONE  = LEN_BITS'(1);

   state_t              state_q, state_d;
   logic [LEN_BITS-1:0] issue_cnt_q, issue_cnt_d;
   logic [LEN_BITS-1:0] words_left_q, words_left_d;
   logic [WIDTH-1:0]    buf_q [2];
   logic [WIDTH-1:0]    buf_d [2];
   logic [1:0]          occ_q, occ_d;
   logic                inflight_q, inflight_d;

   logic [1:0]          outstanding;
   logic [1:0]          occ_after_take;
   logic                pop;
   logic                valid_c;
   logic                xfer;
   logic                take_buf;
   logic                push;
   logic [WIDTH-1:0]    data_c;

   // Buffered words plus the pop whose data is still on fifo_data; never exceeds 2.
   assign outstanding = occ_q + {1'b0, inflight_q};

   assign pop = (state_q == FETCH) && bus.fifo_nempty && (issue_cnt_q != LEN_ZERO)
                && !bus.abort && (outstanding < 2'd2);

   // With an empty buffer the word arriving from the fifo is presented directly,
   // so the first word appears the cycle after its pop.
   assign valid_c  = (state_q == FETCH) && ((occ_q != 2'd0) || inflight_q);
   assign data_c   = (occ_q != 2'd0) ? buf_q[0] : bus.fifo_data;
   assign xfer     = valid_c && bus.m_ready;
   assign take_buf = xfer && (occ_q != 2'd0);
   assign push     = (state_q == FETCH) && inflight_q && !(xfer && (occ_q == 2'd0));

   always_comb begin
      buf_d          = buf_q;
      occ_after_take = occ_q;
      if (take_buf) begin
         buf_d[0]       = buf_q[1];
         occ_after_take = occ_q - 2'd1;
      end
      occ_d = occ_after_take;
      if (push) begin
         buf_d[occ_after_take[0]] = bus.fifo_data;
         occ_d                    = occ_after_take + 2'd1;
      end

      state_d      = state_q;
      issue_cnt_d  = issue_cnt_q;
      words_left_d = words_left_q;
      inflight_d   = pop;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (bus.length != LEN_ZERO) begin
                  state_d      = FETCH;
                  issue_cnt_d  = bus.length;
                  words_left_d = bus.length;
               end else begin
                  state_d = DONE;
               end
            end
         end
         FETCH: begin
            if (pop) begin
               issue_cnt_d = issue_cnt_q - LEN_ONE;
            end
            if (xfer) begin
               words_left_d = words_left_q - LEN_ONE;
            end
            if (bus.abort) begin
               state_d    = FLUSH;
               occ_d      = 2'd0;
               inflight_d = 1'b0;
            end else if (xfer && (words_left_q == LEN_ONE)) begin
               state_d = DONE;
            end
         end
         FLUSH: begin
            state_d      = IDLE;
            issue_cnt_d  = LEN_ZERO;
            words_left_d = LEN_ZERO;
            occ_d        = 2'd0;
            inflight_d   = 1'b0;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         issue_cnt_q  <= LEN_ZERO;
         words_left_q <= LEN_ZERO;
         occ_q        <= 2'd0;
         inflight_q   <= 1'b0;
         buf_q[0]     <= '0;
         buf_q[1]     <= '0;
      end else begin
         state_q      <= state_d;
         issue_cnt_q  <= issue_cnt_d;
         words_left_q <= words_left_d;
         occ_q        <= occ_d;
         inflight_q   <= inflight_d;
         buf_q[0]     <= buf_d[0];
         buf_q[1]     <= buf_d[1];
      end
   end

   assign bus.fifo_pop   = pop;
   assign bus.m_valid    = valid_c;
   assign bus.m_data     = data_c;
   assign bus.m_last     = valid_c && (words_left_q == LEN_ONE);
   assign bus.busy       = (state_q != IDLE);
   assign bus.done       = (state_q == DONE);
   assign bus.words_left = words_left_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader: a small registered-output fifo model feeds
// the reader while a linear sequence of steps checks every cycle of each burst.
module tb_fifo_burst_reader;

   localparam int WIDTH    = 16;
   localparam int LEN_BITS = 8;

   logic clock   = 1'b0;
   logic reset_n = 1'b1;

   always #5 clock = ~clock;

   fifo_burst_reader_if #(.WIDTH(WIDTH), .LEN_BITS(LEN_BITS)) bus ();

   fifo_burst_reader #(.WIDTH(WIDTH), .LEN_BITS(LEN_BITS)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // Fifo model: out_data is registered and updates on the edge that accepts a pop.
   logic [WIDTH-1:0] mem [64];
   logic [5:0]       wr_ptr = 6'd0;
   logic [5:0]       rd_ptr = 6'd0;
   logic [WIDTH-1:0] fifo_q = '0;
   int               bad_pop = 0;

   assign bus.fifo_data   = fifo_q;
   assign bus.fifo_nempty = (wr_ptr != rd_ptr);

   always @(posedge clock) begin
      if (bus.fifo_pop) begin
         if (wr_ptr == rd_ptr) begin
            bad_pop <= bad_pop + 1;
         end else begin
            fifo_q <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 6'd1;
         end
      end
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One cycle's worth of output checks; m_data only matters while m_valid is expected.
   task automatic cyc(input string tag, input logic p, input logic v, input logic [WIDTH-1:0] d,
                      input logic l, input logic b, input logic dn);
      chk({tag, ".pop"},   bus.fifo_pop, p);
      chk({tag, ".valid"}, bus.m_valid,  v);
      if (v) chk({tag, ".data"}, bus.m_data, d);
      chk({tag, ".last"},  bus.m_last,   l);
      chk({tag, ".busy"},  bus.busy,     b);
      chk({tag, ".done"},  bus.done,     dn);
   endtask

   task automatic push(input logic [WIDTH-1:0] w);
      mem[wr_ptr] = w;
      wr_ptr      = wr_ptr + 6'd1;
   endtask

   task automatic step();
      @(posedge clock);
      @(negedge clock);
   endtask

   initial begin
      bus.start  = 1'b0;
      bus.length = '0;
      bus.abort  = 1'b0;
      bus.m_ready = 1'b0;

      // Reset values
      #1 reset_n = 1'b0;
      #1;
      cyc("rst", 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
      chk("rst.words_left", bus.words_left, 8'd0);
      @(negedge clock);
      reset_n = 1'b1;

      // Burst of 4 with m_ready held high: one word per cycle
      push(16'h1111); push(16'h2222); push(16'h3333); push(16'h4444);
      bus.start = 1'b1; bus.length = 8'd4; bus.m_ready = 1'b1;
      #1 chk("t1.idle_pop", bus.fifo_pop, 1'b0);
      step(); bus.start = 1'b0;
      #1 cyc("t1c1", 1'b1, 1'b0, 16'h0,    1'b0, 1'b1, 1'b0);
      chk("t1c1.words_left", bus.words_left, 8'd4);
      step(); #1 cyc("t1c2", 1'b1, 1'b1, 16'h1111, 1'b0, 1'b1, 1'b0);
      step(); #1 cyc("t1c3", 1'b1, 1'b1, 16'h2222, 1'b0, 1'b1, 1'b0);
      step(); #1 cyc("t1c4", 1'b1, 1'b1, 16'h3333, 1'b0, 1'b1, 1'b0);
      step(); #1 cyc("t1c5", 1'b0, 1'b1, 16'h4444, 1'b1, 1'b1, 1'b0);
      chk("t1c5.words_left", bus.words_left, 8'd1);
      step(); #1 cyc("t1c6", 1'b0, 1'b0, 16'h0,    1'b0, 1'b1, 1'b1);
      step(); #1 cyc("t1c7", 1'b0, 1'b0, 16'h0,    1'b0, 1'b0, 1'b0);

      // Burst of 3 with m_ready toggling: data held while stalled, never dropped
      push(16'hA001); push(16'hA002); push(16'hA003);
      bus.start = 1'b1; bus.length = 8'd3;
      step(); bus.start = 1'b0; bus.m_ready = 1'b1;
      #1 cyc("t2c1", 1'b1, 1'b0, 16'h0,    1'b0, 1'b1, 1'b0);
      step(); bus.m_ready = 1'b0;
      #1 cyc("t2c2", 1'b1, 1'b1, 16'hA001, 1'b0, 1'b1, 1'b0);
      step(); bus.m_ready = 1'b1;
      #1 cyc("t2c3", 1'b0, 1'b1, 16'hA001, 1'b0, 1'b1, 1'b0);
      step(); bus.m_ready = 1'b0;
      #1 cyc("t2c4", 1'b1, 1'b1, 16'hA002, 1'b0, 1'b1, 1'b0);
      step(); bus.m_ready = 1'b1;
      #1 cyc("t2c5", 1'b0, 1'b1, 16'hA002, 1'b0, 1'b1, 1'b0);
      step(); bus.m_ready = 1'b0;
      #1 cyc("t2c6", 1'b0, 1'b1, 16'hA003, 1'b1, 1'b1, 1'b0);
      step(); bus.m_ready = 1'b1;
      #1 cyc("t2c7", 1'b0, 1'b1, 16'hA003, 1'b1, 1'b1, 1'b0);
      step(); #1 cyc("t2c8", 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
      step(); #1 cyc("t2c9", 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);

      // Burst of 5 with only 2 words available: stall, then refill
      push(16'hB001); push(16'hB002);
      bus.start = 1'b1; bus.length = 8'd5;
      step(); bus.start = 1'b0;
      #1 cyc("t3c1", 1'b1, 1'b0, 16'h0,    1'b0, 1'b1, 1'b0);
      step(); #1 cyc("t3c2", 1'b1, 1'b1, 16'hB001, 1'b0, 1'b1, 1'b0);
      step(); #1 cyc("t3c3", 1'b0, 1'b1, 16'hB002, 1'b0, 1'b1, 1'b0);
      for (int i = 4; i <= 6; i++) begin
         step(); #1 cyc($sformatf("t3c%0d", i), 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
         chk($sformatf("t3c%0d.words_left", i), bus.words_left, 8'd3);
      end
      step(); push(16'hB003); push(16'hB004); push(16'hB005);
      #1 cyc("t3c7",  1'b1, 1'b0, 16'h0,    1'b0, 1'b1, 1'b0);
      step(); #1 cyc("t3c8",  1'b1, 1'b1, 16'hB003, 1'b0, 1'b1, 1'b0);
      step(); #1 cyc("t3c9",  1'b1, 1'b1, 16'hB004, 1'b0, 1'b1, 1'b0);
      step(); #1 cyc("t3c10", 1'b0, 1'b1, 16'hB005, 1'b1, 1'b1, 1'b0);
      step(); #1 cyc("t3c11", 1'b0, 1'b0, 16'h0,    1'b0, 1'b1, 1'b1);
      step(); #1 cyc("t3c12", 1'b0, 1'b0, 16'h0,    1'b0, 1'b0, 1'b0);

      // Zero-length burst with a non-empty fifo: straight to DONE, no pops
      for (int i = 1; i <= 8; i++) push(16'hD000 + 16'(i));
      bus.start = 1'b1; bus.length = 8'd0;
      step(); bus.start = 1'b0;
      #1 cyc("t4c1", 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
      chk("t4c1.words_left", bus.words_left, 8'd0);
      step(); #1 cyc("t4c2", 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
      chk("t4.fifo_count", 32'(wr_ptr - rd_ptr), 32'd8);

      // Abort one cycle after the 2nd pop of a length-8 burst
      bus.start = 1'b1; bus.length = 8'd8;
      step(); bus.start = 1'b0;
      #1 cyc("t5c1", 1'b1, 1'b0, 16'h0,    1'b0, 1'b1, 1'b0);
      step(); #1 cyc("t5c2", 1'b1, 1'b1, 16'hD001, 1'b0, 1'b1, 1'b0);
      step(); bus.abort = 1'b1; bus.m_ready = 1'b0;
      #1 cyc("t5c3", 1'b0, 1'b1, 16'hD002, 1'b0, 1'b1, 1'b0);
      step(); bus.abort = 1'b0;
      #1 cyc("t5c4", 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
      step(); #1 cyc("t5c5", 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
      chk("t5c5.words_left", bus.words_left, 8'd0);
      chk("t5.fifo_count", 32'(wr_ptr - rd_ptr), 32'd6);

      // Reset mid-burst, then a length-1 burst reads the next word
      bus.start = 1'b1; bus.length = 8'd4;
      step(); bus.start = 1'b0;
      #1 cyc("t6c1", 1'b1, 1'b0, 16'h0,    1'b0, 1'b1, 1'b0);
      step(); #1 cyc("t6c2", 1'b1, 1'b1, 16'hD003, 1'b0, 1'b1, 1'b0);
      reset_n = 1'b0;
      #1 cyc("t6rst", 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
      chk("t6rst.words_left", bus.words_left, 8'd0);
      step();
      reset_n = 1'b1; bus.start = 1'b1; bus.length = 8'd1;
      #1 chk("t6.idle_pop", bus.fifo_pop, 1'b0);
      step(); bus.start = 1'b0; bus.m_ready = 1'b1;
      #1 cyc("t6c3", 1'b1, 1'b0, 16'h0,    1'b0, 1'b1, 1'b0);
      step(); #1 cyc("t6c4", 1'b0, 1'b1, 16'hD004, 1'b1, 1'b1, 1'b0);
      step(); #1 cyc("t6c5", 1'b0, 1'b0, 16'h0,    1'b0, 1'b1, 1'b1);
      step(); #1 cyc("t6c6", 1'b0, 1'b0, 16'h0,    1'b0, 1'b0, 1'b0);

      chk("end.fifo_count", 32'(wr_ptr - rd_ptr), 32'd4);
      chk("end.pop_while_empty", 32'(bad_pop), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
